// File: rtl/ef_pwm_deadtime.sv
// Dead-time insertion stage: turns one PWM waveform into a complementary
// high-side/low-side gate-drive pair with a programmable both-off gap and sticky fault.
module ef_pwm_deadtime #(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dt_rise,
    input  logic [DT_W-1:0] dt_fall,
    input  logic            fault,
    input  logic            fault_clr,
    output logic            hs,
    output logic            ls,
    output logic            dt_active,
    output logic            fault_o
);

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        LS_ON = 3'd1,
        DT_R  = 3'd2,
        HS_ON = 3'd3,
        DT_F  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            pwm_q;
    logic            fault_q, fault_d;
    logic            hs_q, hs_d;
    logic            ls_q, ls_d;
    logic            dt_active_q, dt_active_d;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault | (fault_q & ~fault_clr);

        if (fault || fault_q) begin
            state_d = OFF;
            cnt_d   = '0;
        end else if (!en) begin
            state_d = OFF;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                OFF, LS_ON: begin
                    if (pwm_q) begin
                        if (dt_rise == '0) begin
                            state_d = HS_ON;
                        end else begin
                            state_d = DT_R;
                            cnt_d   = dt_rise;
                        end
                    end else begin
                        state_d = LS_ON;
                    end
                end
                DT_R: begin
                    // A pulse shorter than the dead time aborts back to low side.
                    if (!pwm_q)                     state_d = LS_ON;
                    else if (cnt_q <= DT_W'(1))     state_d = HS_ON;
                    else                            cnt_d   = cnt_q - DT_W'(1);
                end
                HS_ON: begin
                    if (!pwm_q) begin
                        if (dt_fall == '0) begin
                            state_d = LS_ON;
                        end else begin
                            state_d = DT_F;
                            cnt_d   = dt_fall;
                        end
                    end
                end
                DT_F: begin
                    if (pwm_q)                      state_d = HS_ON;
                    else if (cnt_q <= DT_W'(1))     state_d = LS_ON;
                    else                            cnt_d   = cnt_q - DT_W'(1);
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs decode the next state so they are registered alongside it.
        hs_d        = (state_d == HS_ON);
        ls_d        = (state_d == LS_ON);
        dt_active_d = (state_d == DT_R) || (state_d == DT_F);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OFF;
            cnt_q       <= '0;
            pwm_q       <= 1'b0;
            fault_q     <= 1'b0;
            hs_q        <= 1'b0;
            ls_q        <= 1'b0;
            dt_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pwm_q       <= pwm_in;
            fault_q     <= fault_d;
            hs_q        <= hs_d;
            ls_q        <= ls_d;
            dt_active_q <= dt_active_d;
        end
    end

    assign hs        = hs_q;
    assign ls        = ls_q;
    assign dt_active = dt_active_q;
    assign fault_o   = fault_q;

endmodule
